// File: rtl/apb_master_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0]  PSEL_NONE = 3'b000;
  localparam logic [2:0]  PSEL_S0   = 3'b001;
  localparam logic [2:0]  PSEL_S1   = 3'b010;
  localparam logic [2:0]  PSEL_S2   = 3'b100;

  localparam logic [31:0] DEF_SLV_BASE      = 32'h8000_0000;
  localparam int          DEF_SLV_SPAN_LOG2 = 26;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: three equal windows starting at SLV_BASE.
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter logic [31:0] SLV_BASE      = DEF_SLV_BASE,
  parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2
) (
  input  logic [31:0] addr,
  output logic [2:0]  psel,
  output logic        hit
);

  logic [31:0] off;
  logic [31:0] idx;

  always_comb begin
    off  = addr - SLV_BASE;
    idx  = off >> SLV_SPAN_LOG2;
    psel = PSEL_NONE;
    // the >= guard keeps addresses below the base from wrapping into a window
    if (addr >= SLV_BASE) begin
      case (idx)
        32'd0:   psel = PSEL_S0;
        32'd1:   psel = PSEL_S1;
        32'd2:   psel = PSEL_S2;
        default: psel = PSEL_NONE;
      endcase
    end
    hit = |psel;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter for two requesters sharing one APB master port.
module apb_master_arbiter
  import apb_master_pkg::*;
#(
  parameter logic [31:0] SLV_BASE      = DEF_SLV_BASE,
  parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        req0,
  input  logic        req1,
  input  logic        write0,
  input  logic        write1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [2:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA
);

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              rr_last, rr_last_nxt;
  logic              win;
  logic [31:0]       win_addr;
  logic [2:0]        dec_psel;
  logic              dec_hit;

  logic [2:0]        psel_nxt;
  logic              penable_nxt, pwrite_nxt;
  logic [31:0]       paddr_nxt, pwdata_nxt;
  logic [1:0]        done_q, done_nxt;
  logic [1:0]        err_q, err_nxt;
  logic [1:0][31:0]  rdata_q, rdata_nxt;

  // contended: grant the requester not served last; otherwise whoever asks
  always_comb begin
    win      = (req0 && req1) ? ~rr_last : req1;
    win_addr = win ? addr1 : addr0;
  end

  apb_addr_decode #(
    .SLV_BASE      (SLV_BASE),
    .SLV_SPAN_LOG2 (SLV_SPAN_LOG2)
  ) u_dec (
    .addr (win_addr),
    .psel (dec_psel),
    .hit  (dec_hit)
  );

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    rr_last_nxt = rr_last;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    pwrite_nxt  = PWRITE;
    paddr_nxt   = PADDR;
    pwdata_nxt  = PWDATA;
    done_nxt    = 2'b00;
    err_nxt     = 2'b00;
    rdata_nxt   = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nxt     = win;
          rr_last_nxt = win;
          if (dec_hit) begin
            state_nxt   = SETUP;
            psel_nxt    = dec_psel;
            penable_nxt = 1'b0;
            pwrite_nxt  = win ? write1 : write0;
            paddr_nxt   = win_addr;
            pwdata_nxt  = win ? wdata1 : wdata0;
          end else begin
            // decode miss completes without touching the APB bus
            state_nxt     = DONE;
            done_nxt[win] = 1'b1;
            err_nxt[win]  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        state_nxt     = DONE;
        psel_nxt      = PSEL_NONE;
        penable_nxt   = 1'b0;
        done_nxt[gnt] = 1'b1;
        if (!PWRITE) rdata_nxt[gnt] = PRDATA;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr_last <= 1'b1;
      PSEL    <= PSEL_NONE;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      rr_last <= rr_last_nxt;
      PSEL    <= psel_nxt;
      PENABLE <= penable_nxt;
      PWRITE  <= pwrite_nxt;
      PADDR   <= paddr_nxt;
      PWDATA  <= pwdata_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, latency and responses.
module tb_apb_master_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          SPAN = 26;

  logic        Hclk = 1'b0, Hresetn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1, PENABLE, PWRITE;
  logic [31:0] rdata0, rdata1, PADDR, PWDATA, PRDATA;
  logic [2:0]  PSEL;

  apb_master_arbiter #(.SLV_BASE(BASE), .SLV_SPAN_LOG2(SPAN)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 Hclk = ~Hclk;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic [2:0]  psel;
    int          g, d;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   last_id = 1;

  // slave model: PRDATA is meaningful only in the access phase
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    if (a == 32'h8400_0004) return 32'h1234_5678;
    return {a[15:0], ~a[31:16]};
  endfunction

  assign PRDATA = (PSEL != 3'b000 && PENABLE) ? slv_data(PADDR) : 32'hDEAD_BEEF;

  function automatic logic [2:0] ref_psel(input logic [31:0] a);
    logic [63:0] k;
    if (a < BASE) return 3'b000;
    k = (64'(a) - 64'(BASE)) / (64'd1 << SPAN);
    if (k == 64'd0) return 3'b001;
    if (k == 64'd1) return 3'b010;
    if (k == 64'd2) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 4);
    if (k < 3) return BASE + (32'(k) << SPAN) + ($urandom & 32'h03FF_FFFC);
    if (k == 3) return $urandom_range(0, 32'h7FFF_FFFF) & 32'hFFFF_FFFC;
    return 32'h8C00_0000 + ($urandom & 32'h73FF_FFFC);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on each done pulse, checks APB phases against the head
  always @(negedge Hclk) begin
    if (Hresetn) begin
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with nothing outstanding", done0, done1);
        end else begin
          me = sb.pop_front();
          chk("done_id", {done1, done0}, me.id ? 2'b10 : 2'b01);
          chk("done_cycle", cyc, me.d);
          chk(me.id ? "rdata1" : "rdata0", me.id ? rdata1 : rdata0, me.rdata);
          chk(me.id ? "err1" : "err0", me.id ? err1 : err0, me.err);
          chk("done_apb_idle", {PSEL, PENABLE}, 4'b0000);
        end
      end else if (PSEL != 3'b000 || PENABLE) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_apb: PSEL=%0b PENABLE=%0b with nothing outstanding", PSEL, PENABLE);
        end else begin
          me = sb[0];
          chk("psel", PSEL, me.psel);
          chk("paddr", PADDR, me.addr);
          chk("pwrite", PWRITE, me.wr);
          if (me.wr) chk("pwdata", PWDATA, me.wdata);
          chk("apb_phase_cycle", cyc, me.g + (PENABLE ? 2 : 1));
        end
      end
    end
  end

  task automatic issue(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    int   c, first, n, prev_d;
    bit   p0, p1, s0, s1;
    exp_t e;
    @(posedge Hclk); #1;
    c = cyc;
    req0 = r0; req1 = r1; write0 = w0; write1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    first  = (r0 && r1) ? ((last_id == 0) ? 1 : 0) : (r1 ? 1 : 0);
    n      = (r0 && r1) ? 2 : 1;
    prev_d = c - 1;
    for (int i = 0; i < n; i++) begin
      e.id    = (i == 0) ? first : 1 - first;
      e.wr    = e.id ? w1 : w0;
      e.addr  = e.id ? a1 : a0;
      e.wdata = e.id ? d1 : d0;
      e.psel  = ref_psel(e.addr);
      e.err   = (e.psel == 3'b000);
      e.rdata = (e.err || e.wr) ? 32'h0 : slv_data(e.addr);
      e.g     = prev_d + 1;
      e.d     = e.g + (e.err ? 1 : 3);
      prev_d  = e.d;
      sb.push_back(e);
      last_id = e.id;
    end
    p0 = r0; p1 = r1;
    for (int t = 0; t < 40 && (p0 || p1); t++) begin
      @(negedge Hclk); s0 = done0; s1 = done1;
      @(posedge Hclk); #1;
      if (t == 0) begin
        // the granted requester's inputs must be ignored once the transfer is under way
        if (first == 0) begin addr0 = $urandom; wdata0 = $urandom; write0 = ~write0; end
        else            begin addr1 = $urandom; wdata1 = $urandom; write1 = ~write1; end
      end
      if (s0) begin req0 = 1'b0; p0 = 1'b0; end
      if (s1) begin req1 = 1'b0; p1 = 1'b0; end
    end
    if (p0 || p1) begin
      checks++; failures++;
      $display("FAIL timeout: done not seen within 40 cycles, pending0=%0b pending1=%0b", p0, p1);
      req0 = 1'b0; req1 = 1'b0;
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_apb_ctl"}, {PSEL, PENABLE, PWRITE}, 5'b0);
    chk({tag, "_paddr"}, PADDR, 32'h0);
    chk({tag, "_pwdata"}, PWDATA, 32'h0);
    chk({tag, "_done"}, {done1, done0, err1, err0}, 4'b0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 64'h0);
  endtask

  task automatic abort_test();
    exp_t e;
    @(posedge Hclk); #1;
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'h8800_0100; wdata0 = 32'h0BAD_F00D;
    e.id = 0; e.wr = 1'b1; e.addr = addr0; e.wdata = wdata0; e.psel = 3'b100;
    e.err = 1'b0; e.rdata = 32'h0; e.g = cyc; e.d = cyc + 3;
    sb.push_back(e);
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    Hresetn = 1'b0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1; req0 = 1'b0;
    sb.delete();
    last_id = 1;
    @(negedge Hclk);
    chk_all_zero("abort");
    repeat (3) @(negedge Hclk);
  endtask

  initial begin
    logic [31:0] bnd [5];
    int unsigned r;
    bnd[0] = 32'h83FF_FFFC; bnd[1] = 32'h8400_0000; bnd[2] = 32'h8BFF_FFFC;
    bnd[3] = 32'h8C00_0000; bnd[4] = 32'h7FFF_FFFC;

    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    chk_all_zero("reset");
    @(posedge Hclk); #1;
    Hresetn = 1'b1;

    // contended from reset: grant order 0,1,0,1
    issue(1, 1, 1, 0, 32'h8000_0020, 32'h8400_0040, 32'h1111_1111, 32'h0);
    issue(1, 1, 0, 1, 32'h8800_0000, 32'h8000_1000, 32'h0, 32'h2222_2222);
    issue(1, 0, 1, 0, 32'h8000_0010, 32'h0, 32'hA5A5_A5A5, 32'h0);
    issue(0, 1, 0, 0, 32'h0, 32'h8400_0004, 32'h0, 32'h0);
    issue(1, 0, 0, 0, 32'h9000_0000, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) issue(1, 0, 0, 0, bnd[i], 32'h0, 32'h0, 32'h0);
      else            issue(0, 1, 0, 1, 32'h0, bnd[i], 32'h0, 32'hC0DE_0000 + i);
    end

    abort_test();
    issue(1, 0, 0, 0, 32'h8000_0404, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      issue(r[0], r[1], 1'($urandom), 1'($urandom), rand_addr(), rand_addr(), $urandom, $urandom);
    end

    repeat (3) @(negedge Hclk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter SLV_BASE, default 32'h8000_0000, giving the base address of slave 0.
REQ-002 SHALL have parameter SLV_SPAN_LOG2, default 26, giving log2 of the bytes per slave window (64 MB).
REQ-003 SHALL have port Hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Hresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: requester N transfer request, level, held until doneN.
REQ-006 SHALL have ports write0/write1, input, 1 bit each: requester N direction, 1 for write.
REQ-007 SHALL have ports addr0/addr1, input, 32 bits each: requester N byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, 32 bits each: requester N write data.
REQ-009 SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse to requester N.
REQ-010 SHALL have ports rdata0/rdata1, output, 32 bits each: read data, valid while doneN=1.
REQ-011 SHALL have ports err0/err1, output, 1 bit each: decode error, valid while doneN=1.
REQ-012 SHALL have ports PSEL, output, 3 bits: one-hot APB slave select.
REQ-013 SHALL have ports PENABLE and PWRITE, output, 1 bit each: APB enable and direction.
REQ-014 SHALL have ports PADDR and PWDATA, output, 32 bits each: APB address and write data.
REQ-015 SHALL have port PRDATA, input, 32 bits: APB read data.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-017 IDLE: no req, stay; any req, arbitrate, latch winner's addr/wdata/write and decode.
REQ-018 From IDLE, the FSM SHALL go to SETUP on a decode hit and to DONE with err set on a decode miss.
REQ-019 SETUP SHALL drive PSEL one-hot, PENABLE=0, PADDR/PWRITE/PWDATA from the latch, then go to ACCESS.
REQ-020 ACCESS SHALL keep PSEL/PADDR/PWRITE/PWDATA and drive PENABLE=1, capture PRDATA at the cycle end on reads, then go to DONE.
REQ-021 DONE SHALL pulse doneN for the granted requester only, drive rdataN and errN, set PSEL=0 and PENABLE=0, then go to IDLE.
REQ-022 Latency SHALL be: request seen in IDLE at cycle 0, SETUP at 1, ACCESS at 2, doneN at 3; decode miss gives doneN at cycle 1.
REQ-023 Requesters SHALL drop reqN in the cycle after doneN; reqN and inputs SHALL be ignored outside IDLE.
REQ-024 Arbitration SHALL be round-robin: when both request in IDLE, grant the one not served last; with a single request, grant it.
REQ-025 Decode SHALL give PSEL=3'b001/010/100 for addr in [SLV_BASE + k*2^SLV_SPAN_LOG2, next window) for k=0/1/2, and a miss otherwise, including addresses below SLV_BASE.
REQ-026 On writes, rdataN SHALL be 0 in DONE; on errors, rdataN SHALL be 0 and errN=1.
REQ-027 PSEL and PENABLE SHALL be 0 in IDLE and DONE; PADDR/PWDATA SHALL hold their last values outside SETUP/ACCESS.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from reqN to APB outputs.

Reset
REQ-029 Hresetn=0 at a clock edge SHALL force IDLE with PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, done0/1=0, rdata0/1=0, err0/1=0.
REQ-030 Reset SHALL set the round-robin pointer so that req0 wins the first contended arbitration.
REQ-031 Reset during SETUP/ACCESS SHALL abort the transfer silently with no doneN pulse.

Structure
REQ-032 Package apb_master_pkg SHALL hold the FSM state enum, the PSEL one-hot constants and the default base/span constants.
REQ-033 Address decode SHALL be a combinational sub-module apb_addr_decode (addr in; psel, hit out).

Verification
REQ-034 req0 write, addr 32'h8000_0010, wdata 32'hA5A5_A5A5: SETUP at cycle 1 with PSEL=001, PENABLE=1 at cycle 2, done0 at cycle 3, err0=0.
REQ-035 req1 read, addr 32'h8400_0004, PRDATA=32'h1234_5678 in ACCESS: PSEL=010, done1 at cycle 3 with rdata1=32'h1234_5678.
REQ-036 req0 and req1 asserted together from reset and re-asserted after each done: grant order 0,1,0,1; the idle requester's done never pulses.
REQ-037 req0, addr 32'h9000_0000: no PSEL activity, done0 at cycle 1 with err0=1 and rdata0=0.
REQ-038 Hresetn low during ACCESS: next cycle IDLE, all outputs 0, no doneN; a new request then completes normally.
REQ-039 Boundary addresses 32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC and 32'h8C00_0000 SHALL give PSEL 001, 010, 100 and a miss.
